// File: rtl/inv_key_schedule_seq.sv
// inv_key_schedule_seq
//   Iterative AES-128 key expansion for the decryptor. A cipher key accepted
//   on key_valid&&key_ready is expanded one round per clock into an 11-entry
//   round-key store. The store is then read back in decryption order through
//   a registered port with 1-cycle latency.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   key_in       : 128-bit cipher key (round key 0), qualified by key_valid
//   key_ready    : high in IDLE/DONE; a new key is accepted there
//   sched_valid  : all NR+1 round keys stored and readable
//   rd_en        : read request; rd_round selects decryption round 0..NR
//   rd_key       : registered round key (store[NR-rd_round])
//   rd_valid     : rd_key answers a request made while sched_valid was high
module inv_key_schedule_seq #(
    parameter int unsigned NR     = 10,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              sched_valid,
    input  logic              rd_en,
    input  logic [RIDX_W-1:0] rd_round,
    output logic [127:0]      rd_key,
    output logic              rd_valid
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [RIDX_W-1:0] rc);
        logic [7:0] r;
        case (int'(rc))
            0:       r = 8'h01;
            1:       r = 8'h02;
            2:       r = 8'h04;
            3:       r = 8'h08;
            4:       r = 8'h10;
            5:       r = 8'h20;
            6:       r = 8'h40;
            7:       r = 8'h80;
            8:       r = 8'h1b;
            9:       r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // KeyGeneration round function: round key rc+1 from round key rc.
    function automatic logic [127:0] key_generation(input logic [RIDX_W-1:0] rc,
                                                    input logic [127:0]      k);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(rc), 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e              state_q, state_d;
    logic [RIDX_W-1:0]   cnt_q, cnt_d;
    logic [127:0]        work_q, work_d;
    logic                sched_valid_q, sched_valid_d;
    logic [127:0]        rd_key_q, rd_key_d;
    logic                rd_valid_q, rd_valid_d;
    logic [127:0]        store_q [0:NR];
    logic                store_we;
    logic [RIDX_W-1:0]   store_wa;
    logic [127:0]        store_wd;
    logic [127:0]        next_key;
    logic [RIDX_W-1:0]   rd_addr;

    assign next_key    = key_generation(cnt_q, work_q);
    assign rd_addr     = RIDX_W'(NR) - rd_round;
    assign key_ready   = (state_q != EXPAND);
    assign sched_valid = sched_valid_q;
    assign rd_key      = rd_key_q;
    assign rd_valid    = rd_valid_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_d        = work_q;
        sched_valid_d = sched_valid_q;
        store_we      = 1'b0;
        store_wa      = '0;
        store_wd      = '0;
        rd_key_d      = rd_key_q;
        rd_valid_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    store_we      = 1'b1;
                    store_wa      = '0;
                    store_wd      = key_in;
                    work_d        = key_in;
                    cnt_d         = '0;
                    sched_valid_d = 1'b0;
                    state_d       = EXPAND;
                end
            end
            EXPAND: begin
                store_we = 1'b1;
                store_wa = cnt_q + RIDX_W'(1);
                store_wd = next_key;
                work_d   = next_key;
                cnt_d    = cnt_q + RIDX_W'(1);
                if (cnt_q == RIDX_W'(NR - 1)) begin
                    state_d       = DONE;
                    sched_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reads see the store as it was before this edge, so a read that
        // coincides with a restart still returns the previous schedule.
        if (rd_en) begin
            if (rd_round <= RIDX_W'(NR)) begin
                rd_key_d   = store_q[rd_addr];
                rd_valid_d = sched_valid_q;
            end else begin
                rd_key_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            work_q        <= '0;
            sched_valid_q <= 1'b0;
            rd_key_q      <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            work_q        <= work_d;
            sched_valid_q <= sched_valid_d;
            rd_key_q      <= rd_key_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_we && !rst) begin
            store_q[store_wa] <= store_wd;
        end
    end

endmodule

// File: tb/tb_inv_key_schedule_seq.sv
module tb_inv_key_schedule_seq;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         sched_valid;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    int errors = 0;
    int checks = 0;

    inv_key_schedule_seq #(.NR(10), .RIDX_W(4)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .sched_valid(sched_valid), .rd_en(rd_en),
        .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (FIPS-197 arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from multiplicative inverse (a^254) plus affine transform.
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    logic [127:0] m_pend  [0:10];
    logic [127:0] m_store [0:10];
    logic         m_known [0:10];
    int           m_left  = 0;
    logic         m_sched = 1'b0;
    logic         m_rdv   = 1'b0;
    logic [127:0] m_rdk   = '0;
    logic         m_rdk_known = 1'b0;
    logic         m_init  = 1'b0;

    function automatic void expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
                t ^= {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) m_pend[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init      = 1'b1;
            m_left      = 0;
            m_sched     = 1'b0;
            m_rdv       = 1'b0;
            m_rdk       = '0;
            m_rdk_known = 1'b1;
            for (int j = 0; j < 11; j++) m_known[j] = 1'b0;
        end else if (m_init) begin
            if (rd_en) begin
                if (int'(rd_round) <= 10) begin
                    m_rdk       = m_store[10 - int'(rd_round)];
                    m_rdk_known = m_known[10 - int'(rd_round)];
                    m_rdv       = m_sched;
                end else begin
                    m_rdk       = '0;
                    m_rdk_known = 1'b1;
                    m_rdv       = 1'b0;
                end
            end else begin
                m_rdv = 1'b0;
            end
            if (m_left == 0 && key_valid) begin
                expand_key(key_in);
                m_store[0] = key_in;
                m_known[0] = 1'b1;
                m_left     = 10;
                m_sched    = 1'b0;
            end else if (m_left > 0) begin
                m_store[11 - m_left] = m_pend[11 - m_left];
                m_known[11 - m_left] = 1'b1;
                m_left--;
                if (m_left == 0) m_sched = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("key_ready", {127'b0, key_ready}, {127'b0, m_left == 0});
            chk("sched_valid", {127'b0, sched_valid}, {127'b0, m_sched});
            chk("rd_valid", {127'b0, rd_valid}, {127'b0, m_rdv});
            if (m_rdk_known) chk("rd_key", rd_key, m_rdk);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_read(input int r);
        rd_en    = 1'b1;
        rd_round = 4'(r);
        @(negedge clk);
        rd_en    = 1'b0;
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_sched();
        int n;
        n = 0;
        while (!sched_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("sched_timeout", {127'b0, sched_valid}, 128'd1);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_valid = 1'b0; rd_en = 1'b0; rd_round = '0;
        repeat (2) @(negedge clk);
        chk("rst_key_ready", {127'b0, key_ready}, 128'd1);
        chk("rst_sched", {127'b0, sched_valid}, 128'd0);
        chk("rst_rd_key", rd_key, 128'd0);
        chk("rst_rd_valid", {127'b0, rd_valid}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS key; read and foreign key during expansion
        accept_key(K1);
        chk("busy_key_ready", {127'b0, key_ready}, 128'd0);
        repeat (2) @(negedge clk);
        do_read(0);
        chk("expand_rd_valid", {127'b0, rd_valid}, 128'd0);
        accept_key(K2);
        chk("busy_key_ready2", {127'b0, key_ready}, 128'd0);
        wait_sched();
        do_read(0);
        chk("k1_r0", rd_key, K1_R10);
        chk("k1_r0_valid", {127'b0, rd_valid}, 128'd1);
        do_read(9);
        chk("k1_r9", rd_key, K1_R1);
        do_read(10);
        chk("k1_r10", rd_key, K1);

        // back-to-back inverse-order reads
        for (int r = 0; r <= 10; r++) begin
            rd_en    = 1'b1;
            rd_round = 4'(r);
            @(negedge clk);
            chk("b2b_valid", {127'b0, rd_valid}, 128'd1);
            if (r == 0)  chk("b2b_first", rd_key, K1_R10);
            if (r == 10) chk("b2b_last", rd_key, K1);
        end
        rd_en = 1'b0;
        do_read(12);
        chk("oob_key", rd_key, 128'd0);
        chk("oob_valid", {127'b0, rd_valid}, 128'd0);

        // reset mid-expansion, then all-zero key
        accept_key('0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sched", {127'b0, sched_valid}, 128'd0);
        chk("abort_ready", {127'b0, key_ready}, 128'd1);
        accept_key('0);
        wait_sched();
        do_read(0);
        chk("k0_r0", rd_key, K0_R10);

        // restart in DONE with a coincident read
        key_in = K1; key_valid = 1'b1; rd_en = 1'b1; rd_round = 4'd0;
        @(negedge clk);
        key_valid = 1'b0; rd_en = 1'b0;
        chk("restart_rd_key", rd_key, K0_R10);
        chk("restart_rd_valid", {127'b0, rd_valid}, 128'd1);
        chk("restart_sched0", {127'b0, sched_valid}, 128'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("restart_sched_low", {127'b0, sched_valid}, 128'd0);
        end
        @(negedge clk);
        chk("restart_sched_high", {127'b0, sched_valid}, 128'd1);
        do_read(0);
        chk("restart_r0", rd_key, K1_R10);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
